// File: rtl/seq_divider_pkg.sv
// Shared types and sizing constants for the sequential restoring divider.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 32;

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

  localparam int CNT_WIDTH = cnt_width(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, try the subtraction.
module seq_divider_div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic         q_bit
);

  logic [W+1:0] shifted;
  logic [W+1:0] diff;

  // One guard bit above the W+1-bit trial so the borrow shows up in the MSB.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {2'b00, divisor};
    q_bit   = ~diff[W+1];
    rem_out = q_bit ? diff[W:0] : shifted[W:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential DIV/DIVU unit: one restoring step per cycle, sign fix-up, then a done pulse.
//   state | meaning
//   IDLE  | waiting for start
//   CALC  | W restoring steps, MSB first
//   FIX   | apply result signs, register outputs
//   DONE  | results valid, done high; start accepted here too
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = cnt_width(DATA_WIDTH);

  div_state_e       state_q, state_d;
  logic [W:0]       rem_q, rem_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [W-1:0]     quotient_q, quotient_d;
  logic [W-1:0]     remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [W:0]       step_rem;
  logic             step_q;

  function automatic logic [W-1:0] mag(input logic sgn, input logic [W-1:0] x);
    return (sgn && x[W-1]) ? (~x + 1'b1) : x;
  endfunction

  // quo_q doubles as the dividend shifter: dividend bits leave the top, quotient bits enter the bottom.
  seq_divider_div_step #(.W(W)) div_step (
    .rem_in  (rem_q),
    .bit_in  (quo_q[W-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          neg_q_d = is_signed & (dividend[W-1] ^ divisor[W-1]);
          neg_r_d = is_signed & dividend[W-1];
          rem_d   = '0;
          quo_d   = mag(is_signed, dividend);
          dvs_d   = mag(is_signed, divisor);
          cnt_d   = CNT_W'(W - 1);
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = CALC;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[W-2:0], step_q};
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIX: begin
        quotient_d  = neg_q_q ? (~quo_q + 1'b1) : quo_q;
        remainder_d = neg_r_q ? (~rem_q[W-1:0] + 1'b1) : rem_q[W-1:0];
        dbz_d       = 1'b0;
        state_d     = DONE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand/result width; all widths below are DATA_WIDTH (W=32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; accepted only on a rising edge where state is IDLE or DONE.
REQ-005 is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
REQ-006 dividend  input  W  numerator; sampled with start.
REQ-007 divisor  input  W  denominator; sampled with start.
REQ-008 busy  output  1  high in CALC and FIX.
REQ-009 done  output  1  one-cycle pulse; results valid from this cycle.
REQ-010 quotient  output  W  LO result, registered.
REQ-011 remainder  output  W  HI result, registered.
REQ-012 div_by_zero  output  1  registered flag for the last operation; valid with done.

Function
REQ-013 States SHALL be IDLE, CALC, FIX, DONE; transitions only on rising clk.
REQ-014 IDLE/DONE + accepted start with divisor != 0 -> CALC; with divisor == 0 -> DONE directly.
REQ-015 DONE without start -> IDLE; done SHALL be high only while in DONE.
REQ-016 On accept: latch is_signed and operand signs; load magnitudes |dividend|, |divisor| (unsigned mode uses raw values); clear partial remainder; iteration counter = W-1.
REQ-017 CALC SHALL perform one restoring shift-subtract step per cycle (MSB-first, W+1-bit trial subtraction), exactly W cycles, then -> FIX.
REQ-018 FIX (1 cycle) SHALL negate quotient if signs differ and negate remainder if dividend negative (signed mode only), register results, then -> DONE.
REQ-019 Latency: done high exactly W+2 cycles (34) after the accepting edge for divisor != 0; 1 cycle for divisor == 0.
REQ-020 Divide-by-zero: quotient = all ones, remainder = dividend (unmodified), div_by_zero = 1; otherwise div_by_zero = 0.
REQ-021 Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0, div_by_zero = 0, no special path.
REQ-022 Signed results SHALL truncate toward zero; remainder sign follows dividend; |remainder| < |divisor|.
REQ-023 start while busy SHALL be ignored; operand input changes while busy SHALL not affect the result.
REQ-024 start in DONE SHALL be accepted (back-to-back), done dropping next cycle.
REQ-025 quotient/remainder/div_by_zero SHALL hold their values from FIX/DONE until the next FIX or zero-divide DONE; no intermediate values visible.

Reset
REQ-026 rst high on a rising edge SHALL force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
REQ-027 rst mid-CALC/FIX SHALL abort the operation with no done pulse; rst has priority over start.

Structure
REQ-028 Shared package holds: state enum (IDLE, CALC, FIX, DONE), DATA_WIDTH default, counter width constant (log2 W).
REQ-029 One sub-module, div_step: combinational single restoring step (partial remainder, next dividend bit, divisor -> new remainder, quotient bit).
REQ-030 Datapath registers: partial remainder (W+1), quotient shift register (W), divisor (W), counter, sign flags.

Verification
REQ-031 DIVU 100 / 7 -> done at cycle 34, quotient=14, remainder=2, div_by_zero=0.
REQ-032 DIV -7 / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); DIV 7 / -2 -> quotient=-3, remainder=1.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0; DIVU 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0.
REQ-034 DIVU 5 / 0 -> done 1 cycle after start, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
REQ-035 start 50/5, re-pulse start with 9/3 at cycle 10, rst at cycle 20 -> no done, all outputs 0; next start 9/3 -> quotient=3, remainder=0.
REQ-036 Random 10k signed/unsigned pairs incl. 0, ±1, extremes vs. reference model; back-to-back starts in DONE each produce exactly one done.
